ftm_ckpt_mem_responder: RTL and testbench

// - Responder (memory side) of the Ibex-style data interface (req/gnt/rvalid/we/be/addr/wdata/rdata/err).
// - Holds the FT checkpoint store. During recovery the FT module routes core data requests here.
// - Also mirrors committed regfile writes via a snapshot port, so the recovery routine can reload x1..x31.
// - Accepts one request per cycle, in order. Response comes a fixed RESP_LATENCY cycles after grant.

---
 rtl/ftm_ckpt_mem_responder.sv | 143 ++++++++++++++
 tb/tb_ftm_ckpt_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ftm_ckpt_mem_responder.sv
// FT checkpoint store: memory-side responder on the Ibex data bus plus regfile snapshot mirror.
// Optional per-word even parity is enabled by defining FTM_CKPT_PARITY_EN.
module ftm_ckpt_mem_responder #(
    parameter int unsigned DEPTH_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        snap_we_i,
    input  logic [4:0]  snap_addr_i,
    input  logic [31:0] snap_wdata_i,
    output logic        snap_drop_o
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam logic [32:0] BASE_EXT = 33'(BASE_ADDR);
    localparam logic [32:0] END_EXT  = 33'(BASE_ADDR) + 33'(DEPTH_WORDS * BYTES);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
`ifdef FTM_CKPT_PARITY_EN
    logic              mem_par_q [DEPTH_WORDS];
`endif
    resp_t             resp_q [RESP_LATENCY];
    resp_t             resp_d;
    logic              snap_drop_q;
    logic              snap_drop_d;

    logic              gnt;
    logic              addr_err;
    logic              bus_wr;
    logic              snap_hit;
    logic              snap_wr;
    logic              collide;
    logic              par_err;
    logic [IDX_W-1:0]  bus_idx;
    logic [IDX_W-1:0]  snap_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    // Request decode happens in the grant cycle itself
    always_comb begin
        gnt      = enable_i & data_req_i & ~rst_i;
        addr_err = ({1'b0, data_addr_i} < BASE_EXT) ||
                   ({1'b0, data_addr_i} >= END_EXT) ||
                   (data_addr_i[1:0] != 2'b00);
        bus_idx  = data_addr_i[IDX_W+1:2];
        snap_idx = IDX_W'(snap_addr_i);
        rd_word  = mem_q[bus_idx];
        bus_wr   = gnt & data_we_i & ~addr_err;
        snap_hit = snap_we_i & (snap_addr_i != 5'd0);
        collide  = bus_wr & snap_hit & (snap_idx == bus_idx);
        snap_wr  = snap_hit & ~collide;
        merged   = rd_word;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (data_be_i[b]) begin
                merged[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

`ifdef FTM_CKPT_PARITY_EN
    assign par_err = mem_par_q[bus_idx] != (^rd_word);
`else
    assign par_err = 1'b0;
`endif

    // Response entering the pipeline for this cycle's request
    always_comb begin
        resp_d      = '0;
        snap_drop_d = collide;
        if (gnt) begin
            resp_d.valid = 1'b1;
            if (addr_err) begin
                resp_d.err = 1'b1;
            end else if (!data_we_i) begin
                resp_d.rdata = rd_word;
                resp_d.err   = par_err;
            end
        end
    end

    // Storage is deliberately left out of reset; the bus write wins a same-word collision
    always_ff @(posedge clk_i) begin
        if (snap_wr) begin
            mem_q[snap_idx] <= snap_wdata_i;
        end
        if (bus_wr) begin
            mem_q[bus_idx] <= merged;
        end
    end

`ifdef FTM_CKPT_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (snap_wr) begin
            mem_par_q[snap_idx] <= ^snap_wdata_i;
        end
        if (bus_wr) begin
            mem_par_q[bus_idx] <= ^merged;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                resp_q[i] <= '0;
            end
            snap_drop_q <= 1'b0;
        end else begin
            resp_q[0] <= resp_d;
            for (int i = 1; i < int'(RESP_LATENCY); i++) begin
                resp_q[i] <= resp_q[i-1];
            end
            snap_drop_q <= snap_drop_d;
        end
    end

    // Reset suppresses anything still sitting at the pipeline output
    assign data_gnt_o    = gnt;
    assign data_rvalid_o = resp_q[RESP_LATENCY-1].valid & ~rst_i;
    assign data_err_o    = resp_q[RESP_LATENCY-1].err & ~rst_i;
    assign data_rdata_o  = resp_q[RESP_LATENCY-1].rdata & {DATA_W{~rst_i}};
    assign snap_drop_o   = snap_drop_q & ~rst_i;

endmodule

// File: tb/tb_ftm_ckpt_mem_responder.sv
// Bench for ftm_ckpt_mem_responder: directed steps then random traffic, two instances (latency 1 and 3)
// checked against a cycle-indexed behavioural model of storage and expected responses.
module tb_ftm_ckpt_mem_responder;
    localparam int unsigned MAXC = 1024;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, req, we, snap_we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, snap_wdata;
    logic [4:0]  snap_addr;
    logic        gnt1, rv1, err1, drop1;
    logic        gnt3, rv3, err3, drop3;
    logic [31:0] rd1, rd3;

    ftm_ckpt_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .RESP_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .data_req_i(req), .data_gnt_o(gnt1),
        .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd1), .data_err_o(err1), .snap_we_i(snap_we),
        .snap_addr_i(snap_addr), .snap_wdata_i(snap_wdata), .snap_drop_o(drop1));

    ftm_ckpt_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .RESP_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .data_req_i(req), .data_gnt_o(gnt3),
        .data_rvalid_o(rv3), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd3), .data_err_o(err3), .snap_we_i(snap_we),
        .snap_addr_i(snap_addr), .snap_wdata_i(snap_wdata), .snap_drop_o(drop3));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit [31:0] mem_m   [64];
    bit        known_m [64];
    bit        hv [MAXC], herr [MAXC], hknown [MAXC], hrst [MAXC], hcoll [MAXC];
    bit [31:0] hrd [MAXC];
    logic [31:0] bad_tbl [4] = '{32'h0000_0FFC, 32'h0000_1100, 32'h0000_1006, 32'h0000_0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs this cycle for an instance of latency L
    task automatic check_dut(input int L, input logic gn, input logic rv, input logic er,
                             input logic [31:0] rd, input logic dr);
        int g;
        bit ev;
        bit edrop;
        g  = cyc - L;
        ev = 1'b0;
        if (g >= 0 && hv[g]) begin
            ev = 1'b1;
            for (int k = g + 1; k <= cyc; k++) begin
                if (hrst[k]) ev = 1'b0;
            end
        end
        chk($sformatf("rvalid_L%0d", L), 32'(rv), 32'(ev));
        if (ev) begin
            chk($sformatf("err_L%0d", L), 32'(er), 32'(herr[g]));
            if (hknown[g]) chk($sformatf("rdata_L%0d", L), rd, hrd[g]);
        end
        chk($sformatf("gnt_L%0d", L), 32'(gn), 32'(en & req & ~rst));
        edrop = (cyc > 0) && hcoll[cyc-1] && !rst;
        chk($sformatf("snap_drop_L%0d", L), 32'(dr), 32'(edrop));
    endtask

    // Apply this cycle's request and snapshot to the reference storage
    task automatic model_step();
        bit g;
        bit bad;
        bit coll;
        int w;
        g    = en & req & ~rst;
        bad  = (addr < BASE) || (addr >= BASE + 32'd256) || (addr[1:0] != 2'b00);
        w    = bad ? 0 : int'((addr - BASE) / 32'd4);
        coll = 1'b0;
        hv[cyc] = g; herr[cyc] = 1'b0; hrd[cyc] = 32'h0; hknown[cyc] = 1'b1;
        if (g) begin
            if (bad) herr[cyc] = 1'b1;
            else if (!we) begin
                hrd[cyc]    = mem_m[w];
                hknown[cyc] = known_m[w];
            end
        end
        if (snap_we && snap_addr != 5'd0) begin
            if (g && we && !bad && w == int'(snap_addr)) coll = 1'b1;
            else begin
                mem_m[int'(snap_addr)]   = snap_wdata;
                known_m[int'(snap_addr)] = 1'b1;
            end
        end
        if (g && we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_m[w][8*b +: 8] = wdata[8*b +: 8];
            end
            if (be == 4'hF) known_m[w] = 1'b1;
        end
        hcoll[cyc] = coll;
    endtask

    task automatic tick();
        #1;
        hrst[cyc] = rst;
        check_dut(1, gnt1, rv1, err1, rd1, drop1);
        check_dut(3, gnt3, rv3, err3, rd3, drop3);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; req = 1'b1; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic snap(input logic s, input logic [4:0] a, input logic [31:0] d);
        snap_we = s; snap_addr = a; snap_wdata = d;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = BASE; wdata = 32'h0;
        snap(1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 1'b0; req = 1'b1;
        repeat (3) tick();
        chk("gnt_disabled", 32'(gnt1), 32'h0);
        chk("rvalid_disabled", 32'(rv1), 32'h0);

        bus(1'b1, 4'hF, BASE, 32'hDEAD_BEEF); tick();
        chk("wr_rvalid", 32'(rv1), 32'h1);
        chk("wr_err", 32'(err1), 32'h0);
        bus(1'b0, 4'h0, BASE, 32'h0); tick();
        chk("rd_full", rd1, 32'hDEAD_BEEF);

        bus(1'b1, 4'hF, BASE + 4, 32'h1122_3344); tick();
        bus(1'b1, 4'b0101, BASE + 4, 32'hAABB_CCDD); tick();
        bus(1'b0, 4'h0, BASE + 4, 32'h0); tick();
        chk("rd_be_merge", rd1, 32'h11BB_33DD);

        bus(1'b0, 4'h0, BASE, 32'h0); tick();
        bus(1'b0, 4'h0, BASE + 4, 32'h0); tick();
        bus(1'b0, 4'h0, BASE, 32'h0); tick();
        chk("b2b_v0", 32'(rv3), 32'h1);
        chk("b2b_d0", rd3, 32'hDEAD_BEEF);
        req = 1'b0; tick();
        chk("b2b_d1", rd3, 32'h11BB_33DD);
        tick();
        chk("b2b_d2", rd3, 32'hDEAD_BEEF);
        tick();
        chk("b2b_done", 32'(rv3), 32'h0);

        bus(1'b0, 4'h0, 32'h0000_0FFC, 32'h0); tick();
        chk("err_low", 32'(err1), 32'h1);
        chk("err_low_rd", rd1, 32'h0);
        bus(1'b0, 4'h0, 32'h0000_1002, 32'h0); tick();
        chk("err_misal", 32'(err1), 32'h1);
        chk("err_misal_rd", rd1, 32'h0);
        bus(1'b1, 4'hF, 32'h0000_1100, 32'h1234_5678); tick();
        chk("err_high", 32'(err1), 32'h1);
        bus(1'b0, 4'h0, BASE, 32'h0); tick();
        chk("err_no_write", rd1, 32'hDEAD_BEEF);

        req = 1'b0; snap(1'b1, 5'd5, 32'hCAFE_F00D); tick();
        snap(1'b0, 5'd0, 32'h0); bus(1'b0, 4'h0, BASE + 32'h14, 32'h0); tick();
        chk("snap_rd", rd1, 32'hCAFE_F00D);
        snap(1'b1, 5'd5, 32'h5555_5555); bus(1'b1, 4'hF, BASE + 32'h14, 32'h1); tick();
        snap(1'b0, 5'd0, 32'h0); req = 1'b0;
        chk("drop_pulse", 32'(drop1), 32'h1);
        tick();
        chk("drop_once", 32'(drop1), 32'h0);
        bus(1'b0, 4'h0, BASE + 32'h14, 32'h0); tick();
        chk("coll_word", rd1, 32'h0000_0001);

        req = 1'b0; snap(1'b1, 5'd0, 32'hFFFF_FFFF); tick();
        snap(1'b0, 5'd0, 32'h0); bus(1'b0, 4'h0, BASE, 32'h0); tick();
        chk("snap0_ignored", rd1, 32'hDEAD_BEEF);

        bus(1'b0, 4'h0, BASE, 32'h0); tick();
        bus(1'b0, 4'h0, BASE + 4, 32'h0); tick();
        rst = 1'b1; req = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            rst = 1'b0;
            chk("flush_rv3", 32'(rv3), 32'h0);
            chk("flush_rv1", 32'(rv1), 32'h0);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            en    = ($urandom_range(0, 7) != 0);
            req   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            addr  = BASE + 32'($urandom_range(0, 7)) * 32'd4;
            if ($urandom_range(0, 9) == 0) addr = bad_tbl[$urandom_range(0, 3)];
            snap(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            tick();
        end

        rst = 1'b0; req = 1'b0; snap(1'b0, 5'd0, 32'h0);
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
